// File: rtl/fft_stage_sequencer.sv
// Radix-2 FFT butterfly address sequencer.
// Walks the stages, issues (a, b, twiddle) tuples and drains the pipe between stages.
module fft_stage_sequencer #(
  parameter int FFT_POINTS   = 1024,
  parameter int PIPE_LATENCY = 4
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   start,
  input  logic                                   bf_ready,
  output logic                                   bf_valid,
  output logic [$clog2(FFT_POINTS)-1:0]          bf_addr_a,
  output logic [$clog2(FFT_POINTS)-1:0]          bf_addr_b,
  output logic [$clog2(FFT_POINTS)-1:0]          bf_tw_index,
  output logic [$clog2($clog2(FFT_POINTS))-1:0]  bf_stage,
  output logic                                   bf_last,
  output logic                                   busy,
  output logic                                   done
);

  localparam int L  = $clog2(FFT_POINTS);
  localparam int AW = L;
  localparam int SW = $clog2(L);
  localparam int KW = L - 1;

  localparam logic [KW-1:0] K_LAST  = {KW{1'b1}};
  localparam logic [SW-1:0] S_FINAL = SW'(L - 1);
  localparam logic [7:0]    DRAIN_N = 8'(PIPE_LATENCY);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t        r_state;
  logic [SW-1:0] r_s;
  logic [KW-1:0] r_k;
  logic [7:0]    r_drain;

  logic          r_valid;
  logic [AW-1:0] r_a;
  logic [AW-1:0] r_b;
  logic [AW-1:0] r_tw;
  logic [SW-1:0] r_stage;
  logic          r_last;
  logic          r_busy;
  logic          r_done;

  state_t        w_state;
  logic [SW-1:0] w_s;
  logic [KW-1:0] w_k;
  logic [7:0]    w_drain;
  logic          w_hs;

  logic [AW-1:0] w_kx;
  logic [AW-1:0] w_mask;
  logic [AW-1:0] w_j;
  logic [AW-1:0] w_a;
  logic [AW-1:0] w_b;
  logic [AW-1:0] w_tw;
  logic [SW-1:0] w_tw_sh;
  logic          w_issue;

  assign w_hs = (r_state == S_ISSUE) & bf_ready;

  // Next-state, stage, butterfly-index and drain counter.
  always_comb begin
    w_state = r_state;
    w_s     = r_s;
    w_k     = r_k;
    w_drain = r_drain;
    unique case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state = S_ISSUE;
          w_s     = '0;
          w_k     = '0;
        end
      end
      S_ISSUE: begin
        if (w_hs) begin
          if (r_k == K_LAST) begin
            if (PIPE_LATENCY > 0) begin
              w_state = S_DRAIN;
              w_drain = DRAIN_N;
            end else if (r_s == S_FINAL) begin
              w_state = S_DONE;
            end else begin
              w_s = r_s + 1'b1;
              w_k = '0;
            end
          end else begin
            w_k = r_k + 1'b1;
          end
        end
      end
      S_DRAIN: begin
        if (r_drain <= 8'd1) begin
          w_drain = '0;
          if (r_s == S_FINAL) begin
            w_state = S_DONE;
          end else begin
            w_state = S_ISSUE;
            w_s     = r_s + 1'b1;
            w_k     = '0;
          end
        end else begin
          w_drain = r_drain - 8'd1;
        end
      end
      S_DONE: begin
        w_state = S_IDLE;
        w_s     = '0;
        w_k     = '0;
      end
      default: w_state = S_IDLE;
    endcase
  end

  // Tuple for the next cycle: a inserts a zero bit at position s into k.
  always_comb begin
    w_issue = (w_state == S_ISSUE);
    w_kx    = {1'b0, w_k};
    w_mask  = (AW'(1) << w_s) - AW'(1);
    w_j     = w_kx & w_mask;
    w_a     = ((w_kx & ~w_mask) << 1) | w_j;
    w_b     = w_a | (AW'(1) << w_s);
    w_tw_sh = S_FINAL - w_s;
    w_tw    = w_j << w_tw_sh;
    if (!w_issue) begin
      w_a  = '0;
      w_b  = '0;
      w_tw = '0;
    end
  end

  // Control state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_s     <= '0;
      r_k     <= '0;
      r_drain <= '0;
    end else begin
      r_state <= w_state;
      r_s     <= w_s;
      r_k     <= w_k;
      r_drain <= w_drain;
    end
  end

  // Registered outputs derived from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_a     <= '0;
      r_b     <= '0;
      r_tw    <= '0;
      r_stage <= '0;
      r_last  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_valid <= w_issue;
      r_a     <= w_a;
      r_b     <= w_b;
      r_tw    <= w_tw;
      r_stage <= w_s;
      r_last  <= w_issue & (w_k == K_LAST);
      r_busy  <= (w_state != S_IDLE);
      r_done  <= (w_state == S_DONE);
    end
  end

  assign bf_valid    = r_valid;
  assign bf_addr_a   = r_a;
  assign bf_addr_b   = r_b;
  assign bf_tw_index = r_tw;
  assign bf_stage    = r_stage;
  assign bf_last     = r_last;
  assign busy        = r_busy;
  assign done        = r_done;

endmodule

// File: doc/fft_stage_sequencer.md
FFT_STAGE_SEQUENCER -- requirements
Module: fft_stage_sequencer

Interface
REQ-001 SHALL have parameter FFT_POINTS, default 1024, FFT size; power of 2 and at least 4.
REQ-002 SHALL have parameter PIPE_LATENCY, default 4, butterfly datapath latency in cycles, range 0..255.
REQ-003 SHALL define L = log2(FFT_POINTS) and AW = L.
REQ-004 SHALL use one clock and an asynchronous active-low reset.
REQ-005 clk  in  1  rising-edge clock.
REQ-006 rst_n  in  1  asynchronous active-low reset.
REQ-007 start  in  1  request to run one full FFT; sampled only in IDLE.
REQ-008 bf_ready  in  1  datapath accepts the current butterfly.
REQ-009 bf_valid  out  1  a butterfly tuple is presented.
REQ-010 bf_addr_a  out  AW  upper-leg data address.
REQ-011 bf_addr_b  out  AW  lower-leg data address.
REQ-012 bf_tw_index  out  AW  twiddle index for the twiddle LUT, range 0..FFT_POINTS/2-1.
REQ-013 bf_stage  out  clog2(L)  current stage number, 0..L-1.
REQ-014 bf_last  out  1  the current tuple is the last butterfly of its stage.
REQ-015 busy  out  1  high in every state except IDLE.
REQ-016 done  out  1  single-cycle pulse when the FFT completes.

Function
REQ-017 SHALL implement the FSM states IDLE, ISSUE, DRAIN and DONE.
REQ-018 IDLE: start=1 -> ISSUE on the next cycle; stage s=0, group g=0, offset j=0.
REQ-019 ISSUE: bf_valid=1; the tuple is a = g*2^(s+1) + j, b = a + 2^s, tw = j << (L-1-s), bf_stage = s.
REQ-020 A handshake is bf_valid & bf_ready; on a handshake the sequencer SHALL advance j, wrapping at 2^s and incrementing g.
REQ-021 The last butterfly of a stage is g = FFT_POINTS/2^(s+1)-1 and j = 2^s-1; bf_last SHALL be high only on that tuple.
REQ-022 Each stage SHALL issue exactly FFT_POINTS/2 butterflies.
REQ-023 While bf_valid=1 and bf_ready=0, all bf_* outputs SHALL hold stable.
REQ-024 A handshake on the last butterfly with PIPE_LATENCY>0 SHALL go to DRAIN and load the drain counter with PIPE_LATENCY.
REQ-025 DRAIN SHALL last exactly PIPE_LATENCY cycles with bf_valid=0.
REQ-026 When DRAIN exits with s<L-1, the FSM SHALL go to ISSUE with s+1, g=0, j=0.
REQ-027 When DRAIN exits with s=L-1, the FSM SHALL go to DONE.
REQ-028 With PIPE_LATENCY=0, the handshake on the last butterfly SHALL go directly to the next-stage ISSUE, or to DONE for the final stage, with no idle cycle.
REQ-029 DONE SHALL last one cycle with done=1 and then return to IDLE.
REQ-030 start outside IDLE SHALL be ignored, including in DONE.
REQ-031 bf_ready outside ISSUE SHALL be ignored.
REQ-032 All outputs SHALL be registered; there SHALL be no combinational path from input to output.
REQ-033 Address arithmetic SHALL be unsigned AW-bit and SHALL never exceed FFT_POINTS-1.

Reset
REQ-034 While rst_n=0, the FSM SHALL be in IDLE.
REQ-035 While rst_n=0, bf_valid, done, busy and bf_last SHALL be 0.
REQ-036 While rst_n=0, bf_addr_a, bf_addr_b, bf_tw_index, bf_stage and the drain counter SHALL be 0.
REQ-037 Reset asserted mid-run SHALL abort immediately with no done pulse.
REQ-038 After reset, the block SHALL need a new start to run.

Verification
REQ-039 FFT_POINTS=8, PIPE_LATENCY=2, bf_ready=1, start at cycle 0 -> stage 0 tuples (a,b,tw) are (0,1,0),(2,3,0),(4,5,0),(6,7,0) on cycles 1-4.
REQ-040 Same run -> DRAIN on cycles 5-6 and stage 1 tuples (0,2,0),(1,3,2),(4,6,0),(5,7,2) on cycles 7-10.
REQ-041 Same run -> DRAIN on cycles 11-12 and stage 2 tuples (0,4,0),(1,5,1),(2,6,2),(3,7,3) on cycles 13-16.
REQ-042 Same run -> DRAIN on cycles 17-18, done=1 only on cycle 19, busy=1 on cycles 1-19.
REQ-043 Backpressure: bf_ready toggling randomly -> the tuple sequence is identical to the bf_ready=1 run and outputs stay stable during stalls.
REQ-044 PIPE_LATENCY=0 with FFT_POINTS=8 -> 12 consecutive valid cycles and done on the following cycle.
REQ-045 start pulsed during ISSUE and during DONE -> no restart; start in IDLE after done -> a clean second run.
REQ-046 rst_n=0 during stage 1 -> all outputs go to 0 asynchronously, no done pulse, and the block stays in IDLE until start.
REQ-047 FFT_POINTS=1024 default run with ready=1 -> 5120 handshakes, bf_last count = 10, maximum address 1023, maximum tw 511.
